lfsr_rand_gen: RTL and testbench
================================

LFSR_RAND_GEN -- requirements
Module: lfsr_rand_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: LFSR state width, 4..32.
REQ-002 SHALL have parameter TAPS, default 8'h1D: Galois feedback mask, WIDTH bits, polynomial x^8+x^4+x^3+x^2+1.
REQ-003 SHALL have parameter SEED, default all-ones: reset value, and fallback for a zero seed; nonzero.
REQ-004 SHALL have parameter OUT_W, default 6: random-output and limit width, 1..WIDTH.
REQ-005 SHALL have parameter MAX_TRIES, default 4: rejection-sampling attempt bound, >=1.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 en  in  1  free-run step enable.
REQ-009 seed_load  in  1  single-cycle seed load strobe.
REQ-010 seed_in  in  WIDTH  seed value.
REQ-011 state  out  WIDTH  current LFSR register.
REQ-012 req_valid  in  1  range request valid.
REQ-013 req_ready  out  1  high only in IDLE.
REQ-014 req_limit  in  OUT_W  exclusive upper bound.
REQ-015 rsp_valid  out  1  high only in DONE.
REQ-016 rsp_ready  in  1  consumer accepts result.
REQ-017 rsp_data  out  OUT_W  result, < req_limit when req_limit >= 1.

Function
REQ-018 SHALL step as: next = {state[WIDTH-2:0],0} XOR (state[WIDTH-1] ? TAPS : 0).
REQ-019 SHALL step when en=1, and on every DRAW cycle regardless of en; otherwise hold.
REQ-020 seed_load SHALL take priority over stepping: state <= seed_in, or SEED if seed_in==0; it never produces all-zero.
REQ-021 If state is ever all-zero, the next edge SHALL load SEED (lockup recovery).
REQ-022 FSM states SHALL be IDLE, DRAW and DONE.
REQ-023 IDLE to DRAW on req_valid&&req_ready; latches limit L and mask M = smallest 2^k-1 >= L-1, with M=0 for L<=1; clears try counter.
REQ-024 DRAW SHALL form candidate C = state[OUT_W-1:0] & M.
- C<L, or L==0: rsp_data<=C (0 if L==0); go to DONE.
- Else, tries < MAX_TRIES-1: tries+1; stay in DRAW.
- Else: rsp_data<=C-L; go to DONE.
REQ-025 DONE SHALL hold rsp_valid and rsp_data stable until rsp_ready; then go to IDLE on that edge.
REQ-026 Latency: accept at edge N; rsp_valid from edge N+1+t, t = rejected draws (0..MAX_TRIES-1).
REQ-027 seed_load during DRAW SHALL load the seed and skip that cycle's step; the candidate evaluation for the cycle is unchanged and the FSM continues.
REQ-028 req_valid outside IDLE SHALL be ignored (req_ready=0).

Reset
REQ-029 rst SHALL asynchronously force state=SEED, FSM=IDLE, tries=0, rsp_data=0, rsp_valid=0 and req_ready=1 after release.
REQ-030 rst mid-request SHALL abandon the request with no response.

Structure
REQ-031 The shared package SHALL hold the FSM state enum and the default polynomial/seed constants for widths 8, 16 and 32.
REQ-032 SHALL instantiate one sub-module, lfsr_core (step, load, lockup recovery); the FSM SHALL live at top level.

Verification
REQ-033 Reset, then en=1: state 0xFF then 0xE3 then 0xDB; state returns to 0xFF after exactly 255 steps, with no zero state.
REQ-034 seed_load with seed_in=0x00 -> state=0xFF next cycle; seed_in=0x5A -> 0x5A.
REQ-035 seed 0x05, en=0, req_limit=6 -> rsp_data=5, rsp_valid one cycle after acceptance.
REQ-036 seed 0x07, en=0, req_limit=6 -> rejects 7 and 6 (states 0x07, 0x0E), accepts state 0x1C -> rsp_data=4 after 3 DRAW cycles.
REQ-037 req_limit=1 -> rsp_data=0; hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0.
REQ-038 Assert rst during DRAW -> rsp_valid=0, state=SEED, FSM=IDLE immediately; no response after release.

Source files
------------

// File: rtl/lfsr_rand_gen_pkg.sv
// Shared types and constants for the LFSR random generator: FSM encoding,
// default Galois polynomials and seeds, and the range-mask helper.
package lfsr_rand_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Galois masks hold the polynomial terms below x^WIDTH.
  localparam logic [7:0]  LFSR_POLY_8  = 8'h1D;        // x^8+x^4+x^3+x^2+1
  localparam logic [15:0] LFSR_POLY_16 = 16'hA011;     // x^16+x^15+x^13+x^4+1
  localparam logic [31:0] LFSR_POLY_32 = 32'h0040_0007; // x^32+x^22+x^2+x+1

  localparam logic [7:0]  LFSR_SEED_8  = 8'hFF;
  localparam logic [15:0] LFSR_SEED_16 = 16'hFFFF;
  localparam logic [31:0] LFSR_SEED_32 = 32'hFFFF_FFFF;

  // Smallest 2^k-1 covering lim-1; zero when lim <= 1.
  function automatic logic [31:0] range_mask(input logic [31:0] lim);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++)
      if (m < lim - 32'd1) m = {m[30:0], 1'b1};
    if (lim <= 32'd1) m = '0;
    return m;
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_core.sv
// Galois LFSR register with seed load and all-zero lockup recovery.
module lfsr_core #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] nxt;

  assign nxt = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);

  // A zero seed would lock the register, so it maps to SEED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 state <= SEED;
    else if (load)           state <= (seed_in == '0) ? SEED : seed_in;
    else if (state == '0)    state <= SEED;
    else if (step)           state <= nxt;
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Range-limited random draws from an LFSR using bounded rejection sampling.
module lfsr_rand_gen
  import lfsr_rand_gen_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_POLY_8),
  parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
  parameter int               OUT_W     = 6,
  parameter int               MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  fsm_e             fsm, fsm_n;
  logic [TRY_W-1:0] tries, tries_n;
  logic [OUT_W-1:0] lim, lim_n, mask, mask_n, data_n, cand;
  logic             step;

  assign step      = en || (fsm == DRAW);
  assign req_ready = (fsm == IDLE);
  assign rsp_valid = (fsm == DONE);
  assign cand      = state[OUT_W-1:0] & mask;

  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .load    (seed_load),
    .seed_in (seed_in),
    .state   (state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm      <= IDLE;
      tries    <= '0;
      lim      <= '0;
      mask     <= '0;
      rsp_data <= '0;
    end else begin
      fsm      <= fsm_n;
      tries    <= tries_n;
      lim      <= lim_n;
      mask     <= mask_n;
      rsp_data <= data_n;
    end
  end

  always_comb begin
    fsm_n   = fsm;
    tries_n = tries;
    lim_n   = lim;
    mask_n  = mask;
    data_n  = rsp_data;
    case (fsm)
      IDLE: if (req_valid) begin
        fsm_n   = DRAW;
        lim_n   = req_limit;
        mask_n  = OUT_W'(range_mask(32'(req_limit)));
        tries_n = '0;
      end
      DRAW: begin
        if (cand < lim || lim == '0) begin
          data_n = (lim == '0) ? '0 : cand;
          fsm_n  = DONE;
        end else if (tries < TRY_W'(MAX_TRIES - 1)) begin
          tries_n = tries + 1'b1;
        end else begin
          // mask < 2*lim, so folding once always lands in range
          data_n = cand - lim;
          fsm_n  = DONE;
        end
      end
      DONE: if (rsp_ready) fsm_n = IDLE;
      default: fsm_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Scoreboard bench for lfsr_rand_gen with default parameters.
module tb_lfsr_rand_gen;

  logic       clk = 1'b0;
  logic       rst, en, seed_load, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] seed_in, state;
  logic [5:0] req_limit, rsp_data;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [5:0] data; int lat; } exp_t;
  exp_t sb[$];

  lfsr_rand_gen dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .state(state), .req_valid(req_valid), .req_ready(req_ready),
    .req_limit(req_limit), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_step(input logic [7:0] s);
    logic [7:0] r;
    r = s << 1;
    if (s[7]) r = r ^ 8'h1D;
    return r;
  endfunction

  function automatic int m_mask(input int l);
    int k;
    if (l <= 1) return 0;
    k = 0;
    while (((1 << k) - 1) < (l - 1)) k++;
    return (1 << k) - 1;
  endfunction

  // Walks rejection sampling from state s (en=0), returns result and rejections.
  task automatic m_draw(input logic [7:0] s, input int l,
                        output logic [5:0] d, output int lat, output bit fb);
    int c, m;
    m  = m_mask(l);
    fb = 0;
    d  = '0;
    lat = 0;
    for (int t = 0; t < 4; t++) begin
      c = int'(s[5:0]) & m;
      lat = t;
      if (l == 0) begin d = '0; return; end
      if (c < l) begin d = 6'(c); return; end
      if (t == 3) begin d = 6'(c - l); fb = 1; return; end
      s = m_step(s);
    end
  endtask

  task automatic load_seed(input logic [7:0] s);
    logic [7:0] exp_s;
    exp_s = (s == 8'h00) ? 8'hFF : s;
    seed_load = 1'b1; seed_in = s;
    @(negedge clk);
    seed_load = 1'b0;
    total++;
    if (state !== exp_s) begin
      bad++; $display("FAIL seed_load got=%h exp=%h", state, exp_s);
    end
  endtask

  // Issue one request from seed s; hold extends DONE with rsp_ready low.
  task automatic do_req(input logic [7:0] s, input logic [5:0] l, input int hold);
    exp_t e;
    bit   fb;
    int   k;
    load_seed(s);
    m_draw((s == 8'h00) ? 8'hFF : s, int'(l), e.data, e.lat, fb);
    sb.push_back(e);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_limit = l;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    e = sb.pop_front();
    total++;
    if (k >= 20) begin bad++; $display("FAIL rsp_timeout got=%0d exp=%0d", k, e.lat + 1); end
    else if (k != e.lat + 1) begin bad++; $display("FAIL latency got=%0d exp=%0d", k, e.lat + 1); end
    total++;
    if (rsp_data !== e.data) begin bad++; $display("FAIL rsp_data got=%0d exp=%0d", rsp_data, e.data); end
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold got=%b/%0d/%b exp=1/%0d/0", rsp_valid, rsp_data, req_ready, e.data);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL return_idle got=%b/%b exp=1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = '0;
    req_valid = 1'b0; req_limit = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 8'hFF || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 6'd0) begin
      bad++;
      $display("FAIL reset got=%h/%b/%b/%0d exp=ff/1/0/0", state, req_ready, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_free_run();
    int  n;
    bit  zero_seen;
    en = 1'b1;
    @(negedge clk);
    total++;
    if (state !== 8'hE3) begin bad++; $display("FAIL step1 got=%h exp=e3", state); end
    @(negedge clk);
    total++;
    if (state !== 8'hDB) begin bad++; $display("FAIL step2 got=%h exp=db", state); end
    n = 2; zero_seen = 0;
    while (state !== 8'hFF && n < 300) begin
      @(negedge clk); n++;
      if (state === 8'h00) zero_seen = 1;
    end
    en = 1'b0;
    total++;
    if (n != 255 || zero_seen) begin bad++; $display("FAIL period got=%0d zero=%b exp=255 zero=0", n, zero_seen); end
  endtask

  task automatic test_seed_load();
    load_seed(8'h5A);
    load_seed(8'h00);
  endtask

  task automatic test_draws();
    do_req(8'h05, 6'd6, 0);
    do_req(8'h07, 6'd6, 0);
    do_req(8'h33, 6'd1, 5);
    do_req(8'h9C, 6'd0, 0);
  endtask

  task automatic test_fallback();
    logic [5:0] d;
    int lat, fs, fl;
    bit fb;
    fs = -1; fl = 0;
    for (int l = 2; l < 64 && fs < 0; l++)
      for (int s = 1; s < 256 && fs < 0; s++) begin
        m_draw(8'(s), l, d, lat, fb);
        if (fb) begin fs = s; fl = l; end
      end
    total++;
    if (fs < 0) begin bad++; $display("FAIL fallback_seed got=none exp=found"); end
    else do_req(8'(fs), 6'(fl), 0);
  endtask

  // seed 0x07 rejects 7, the load replaces the step so 0x05 is drawn next.
  task automatic test_load_in_draw();
    int k;
    load_seed(8'h07);
    req_valid = 1'b1; req_limit = 6'd6;
    @(negedge clk);
    req_valid = 1'b0;
    seed_load = 1'b1; seed_in = 8'h05;
    @(negedge clk);
    seed_load = 1'b0;
    total++;
    if (state !== 8'h05 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL load_in_draw got=%h/%b exp=05/0", state, rsp_valid);
    end
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    total++;
    if (k != 1 || rsp_data !== 6'd5) begin
      bad++; $display("FAIL load_in_draw_rsp got=%0d/%0d exp=1/5", k, rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    load_seed(8'h07);
    req_valid = 1'b1; req_limit = 6'd6;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || state !== 8'hFF || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid got=%b/%h/%b exp=0/ff/1", rsp_valid, state, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_rsp got=%b exp=0", rsp_valid); end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      do_req(8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), 0);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_seed_load();
    test_draws();
    test_fallback();
    test_load_in_draw();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
